// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - CPU-side memory responder with programmable wait states and backdoor loader
// One access at a time: IDLE accepts, WAIT burns WAIT_CYCLES cycles, RESP commits/reads and answers.
module mem_responder #(
    parameter int WAIT_CYCLES = 1,
    parameter int DEPTH       = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] addr,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] wdata,
    input  logic       ld_en,
    input  logic [4:0] ld_addr,
    input  logic [7:0] ld_data,
    output logic [7:0] rdata,
    output logic       ready,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] CNT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    state_t     state;
    state_t     next_state;
    logic [2:0] cnt;
    logic [4:0] cap_addr;
    logic [7:0] cap_wdata;
    logic       cap_wr;
    logic [7:0] mem [0:DEPTH-1];

    logic       accept;
    logic       load;
    logic       bad;
    logic       enter_resp;
    logic [4:0] acc_addr;
    logic [7:0] acc_wdata;
    logic       acc_wr;

    // With zero wait cycles the access completes on the accepting edge, so the
    // live bus values stand in for the not-yet-captured ones.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        load       = 1'b0;
        bad        = 1'b0;
        acc_addr   = cap_addr;
        acc_wdata  = cap_wdata;
        acc_wr     = cap_wr;
        case (state)
            IDLE: begin
                if (ld_en) begin
                    load = 1'b1;
                end else if (rd && wr) begin
                    bad = 1'b1;
                end else if (rd || wr) begin
                    accept     = 1'b1;
                    next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
                    acc_addr   = addr;
                    acc_wdata  = wdata;
                    acc_wr     = wr;
                end
            end
            WAIT: begin
                if (cnt == 3'd0) next_state = RESP;
            end
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
        enter_resp = (next_state == RESP) && (state != RESP);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            cap_addr  <= 5'd0;
            cap_wdata <= 8'h00;
            cap_wr    <= 1'b0;
            rdata     <= 8'h00;
            ready     <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= next_state;
            ready <= (state == RESP);
            err   <= bad;
            if (accept) begin
                cap_addr  <= addr;
                cap_wdata <= wdata;
                cap_wr    <= wr;
                cnt       <= CNT_INIT;
            end else if (state == WAIT && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
            if (enter_resp && !acc_wr) rdata <= mem[acc_addr];
        end
    end

    // Storage is deliberately not reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (load) begin
                mem[ld_addr] <= ld_data;
            end else if (enter_resp && acc_wr) begin
                mem[acc_addr] <= acc_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - table-driven bench for mem_responder (WAIT_CYCLES=1 and WAIT_CYCLES=0 instances)
module tb_mem_responder;

    logic       clk;
    logic       rst_n;
    logic [4:0] addr;
    logic       rd;
    logic       wr;
    logic [7:0] wdata;
    logic       ld_en;
    logic [4:0] ld_addr;
    logic [7:0] ld_data;
    logic [7:0] rdata1, rdata0;
    logic       ready1, ready0;
    logic       busy1, busy0;
    logic       err1, err0;

    int checks = 0;
    int errors = 0;
    int rdy_cnt = 0;
    int err_cnt = 0;

    mem_responder #(.WAIT_CYCLES(1), .DEPTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .rd(rd), .wr(wr), .wdata(wdata),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rdata(rdata1), .ready(ready1), .busy(busy1), .err(err1)
    );

    mem_responder #(.WAIT_CYCLES(0), .DEPTH(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .rd(rd), .wr(wr), .wdata(wdata),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (ready1) rdy_cnt++;
        if (err1) err_cnt++;
    end

    typedef struct {
        logic       ld_en;
        logic [4:0] ld_addr;
        logic [7:0] ld_data;
        logic       rd;
        logic       wr;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic       e_ready;
        logic       e_err;
        logic       e_busy;
        logic [7:0] e_rdata;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    function automatic vec_t mk(logic l, logic [4:0] la, logic [7:0] ld, logic r, logic w,
                                logic [4:0] a, logic [7:0] wd, logic er, logic ee,
                                logic eb, logic [7:0] erd);
        vec_t v;
        v.ld_en = l; v.ld_addr = la; v.ld_data = ld; v.rd = r; v.wr = w;
        v.addr = a; v.wdata = wd; v.e_ready = er; v.e_err = ee; v.e_busy = eb; v.e_rdata = erd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ld_en = 1'b0; ld_addr = 5'd0; ld_data = 8'h00;
        rd = 1'b0; wr = 1'b0; addr = 5'd0; wdata = 8'h00;
    endtask

    initial begin
        //                 ld la     ldata  rd wr addr   wdata  rdy err busy rdata
        tbl[0]  = mk(1, 5'd3,  8'hA5, 0, 0, 5'd0,  8'h00, 0, 0, 0, 8'h00);
        tbl[1]  = mk(1, 5'd5,  8'h11, 0, 0, 5'd0,  8'h00, 0, 0, 0, 8'h00);
        tbl[2]  = mk(0, 5'd0,  8'h00, 1, 0, 5'd3,  8'h00, 0, 0, 1, 8'h00);
        tbl[3]  = mk(0, 5'd0,  8'h00, 0, 0, 5'd0,  8'h00, 0, 0, 1, 8'hA5);
        tbl[4]  = mk(0, 5'd0,  8'h00, 0, 0, 5'd0,  8'h00, 1, 0, 0, 8'hA5);
        tbl[5]  = mk(0, 5'd0,  8'h00, 0, 1, 5'd31, 8'h3C, 0, 0, 1, 8'hA5);
        tbl[6]  = mk(0, 5'd0,  8'h00, 0, 0, 5'd0,  8'h00, 0, 0, 1, 8'hA5);
        tbl[7]  = mk(0, 5'd0,  8'h00, 0, 0, 5'd0,  8'h00, 1, 0, 0, 8'hA5);
        tbl[8]  = mk(0, 5'd0,  8'h00, 1, 0, 5'd31, 8'h00, 0, 0, 1, 8'hA5);
        tbl[9]  = mk(0, 5'd0,  8'h00, 0, 0, 5'd0,  8'h00, 0, 0, 1, 8'h3C);
        tbl[10] = mk(0, 5'd0,  8'h00, 0, 0, 5'd0,  8'h00, 1, 0, 0, 8'h3C);
        tbl[11] = mk(0, 5'd0,  8'h00, 1, 1, 5'd3,  8'h00, 0, 1, 0, 8'h3C);
        tbl[12] = mk(0, 5'd0,  8'h00, 0, 0, 5'd0,  8'h00, 0, 0, 0, 8'h3C);
        tbl[13] = mk(0, 5'd0,  8'h00, 1, 0, 5'd3,  8'h00, 0, 0, 1, 8'h3C);
        tbl[14] = mk(0, 5'd0,  8'h00, 0, 0, 5'd0,  8'h00, 0, 0, 1, 8'hA5);
        tbl[15] = mk(0, 5'd0,  8'h00, 0, 0, 5'd0,  8'h00, 1, 0, 0, 8'hA5);
        tbl[16] = mk(1, 5'd7,  8'h5A, 1, 0, 5'd7,  8'h00, 0, 0, 0, 8'hA5);
        tbl[17] = mk(0, 5'd0,  8'h00, 1, 0, 5'd7,  8'h00, 0, 0, 1, 8'hA5);
        tbl[18] = mk(0, 5'd0,  8'h00, 0, 0, 5'd0,  8'h00, 0, 0, 1, 8'h5A);
        tbl[19] = mk(0, 5'd0,  8'h00, 0, 0, 5'd0,  8'h00, 1, 0, 0, 8'h5A);

        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", ready1, 1'b0);
        chk("reset_err",   err1,   1'b0);
        chk("reset_busy",  busy1,  1'b0);
        chk("reset_rdata", rdata1, 8'h00);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            ld_en = tbl[i].ld_en; ld_addr = tbl[i].ld_addr; ld_data = tbl[i].ld_data;
            rd = tbl[i].rd; wr = tbl[i].wr; addr = tbl[i].addr; wdata = tbl[i].wdata;
            @(negedge clk);
            chk($sformatf("row%0d_ready", i), ready1, tbl[i].e_ready);
            chk($sformatf("row%0d_err",   i), err1,   tbl[i].e_err);
            chk($sformatf("row%0d_busy",  i), busy1,  tbl[i].e_busy);
            chk($sformatf("row%0d_rdata", i), rdata1, tbl[i].e_rdata);
        end

        // Write FF over 11 at address 5, then abort it with reset while in WAIT.
        idle_inputs();
        wr = 1'b1; addr = 5'd5; wdata = 8'hFF;
        @(negedge clk);
        chk("abort_in_wait_busy", busy1, 1'b1);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("abort_rst_ready", ready1, 1'b0);
        chk("abort_rst_err",   err1,   1'b0);
        chk("abort_rst_busy",  busy1,  1'b0);
        chk("abort_rst_rdata", rdata1, 8'h00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("abort_hold%0d_ready", k), ready1, 1'b0);
        end
        rst_n = 1'b1;
        rd = 1'b1; addr = 5'd5;
        @(negedge clk);
        chk("reread_busy", busy1, 1'b1);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        chk("reread_ready", ready1, 1'b1);
        chk("reread_rdata", rdata1, 8'h11);
        @(negedge clk);
        chk("ready_pulse_count", 8'(rdy_cnt), 8'd6);
        chk("err_pulse_count",   8'(err_cnt), 8'd1);

        // Zero-wait instance: rd held high, loader strobed only while in RESP.
        ld_en = 1'b1; ld_addr = 5'd9; ld_data = 8'hC3;
        @(negedge clk);
        idle_inputs();
        rd = 1'b1; addr = 5'd9;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("w0_edge%0d_ready", k), ready0, (k % 2 == 0) ? 1'b1 : 1'b0);
            chk($sformatf("w0_edge%0d_busy",  k), busy0,  (k % 2 == 1) ? 1'b1 : 1'b0);
            if (k % 2 == 0) chk($sformatf("w0_edge%0d_rdata", k), rdata0, 8'hC3);
            ld_en   = (k % 2 == 1);
            ld_addr = 5'd9;
            ld_data = 8'h00;
        end
        idle_inputs();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
